// File: rtl/axi_stream_pkg.sv
// -----------------------------------------------------------------------------
// axi_stream_pkg
// Shared definitions for the AXI Stream header strip path:
//   - AXIS_DATA_WD : default stream data width in bits
//   - state_t      : packet state machine encoding
//   - keep_count   : number of leading (MSB-side) ones in a keep vector
//   - keep_from_count : MSB-contiguous keep vector holding a given byte count
// The helper functions are sized for the default data width.
// -----------------------------------------------------------------------------
package axi_stream_pkg;

    localparam int AXIS_DATA_WD = 32;
    localparam int AXIS_BYTE_WD = AXIS_DATA_WD / 8;
    localparam int AXIS_CNT_WD  = $clog2(AXIS_BYTE_WD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        STREAM = 2'd2,
        TAIL   = 2'd3
    } state_t;

    // Counts ones starting at the MSB lane and stops at the first zero.
    function automatic logic [AXIS_CNT_WD:0] keep_count(input logic [AXIS_BYTE_WD-1:0] keep);
        logic [AXIS_CNT_WD:0] cnt;
        logic                 run;
        cnt = '0;
        run = 1'b1;
        for (int i = AXIS_BYTE_WD - 1; i >= 0; i--) begin
            if (run && keep[i]) begin
                cnt = cnt + {{AXIS_CNT_WD{1'b0}}, 1'b1};
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    // cnt = 0 gives all zeros, cnt = AXIS_BYTE_WD gives all ones.
    function automatic logic [AXIS_BYTE_WD-1:0] keep_from_count(input logic [AXIS_CNT_WD:0] cnt);
        logic [AXIS_BYTE_WD-1:0] ones;
        ones = '1;
        return ~(ones >> cnt);
    endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// -----------------------------------------------------------------------------
// axis_byte_realign
// Combinational byte realignment for the header strip path. All words are
// MSB-justified (lane DATA_BYTE_WD-1 is the first byte on the wire).
//   i_residue   : bytes left over from the previous beat, zero-filled
//   i_res_cnt   : number of valid bytes in i_residue (R)
//   i_beat      : incoming beat data
//   i_beat_keep : incoming beat byte enables (MSB-contiguous)
//   i_strip     : strip byte count S (1..DATA_BYTE_WD)
//   o_header    : top S bytes of the masked beat, zero-filled below
//   o_merged    : residue followed by the leading bytes of the beat
//   o_leftover  : beat bytes below the top S lanes, shifted up to the MSB
//   o_beat_cnt  : valid byte count of the beat (L)
//   o_out_cnt   : R+L, meaningful when o_fits is set
//   o_fits      : R+L fits into a single output beat
//   o_tail_cnt  : R+L-DATA_BYTE_WD, meaningful when o_fits is clear
// -----------------------------------------------------------------------------
module axis_byte_realign
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = AXIS_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]      i_residue,
    input  logic [BYTE_CNT_WD:0]    i_res_cnt,
    input  logic [DATA_WD-1:0]      i_beat,
    input  logic [DATA_BYTE_WD-1:0] i_beat_keep,
    input  logic [BYTE_CNT_WD:0]    i_strip,
    output logic [DATA_WD-1:0]      o_header,
    output logic [DATA_WD-1:0]      o_merged,
    output logic [DATA_WD-1:0]      o_leftover,
    output logic [BYTE_CNT_WD:0]    o_beat_cnt,
    output logic [BYTE_CNT_WD:0]    o_out_cnt,
    output logic                    o_fits,
    output logic [BYTE_CNT_WD:0]    o_tail_cnt
);

    localparam logic [BYTE_CNT_WD:0]   FULL_CNT   = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
    localparam logic [BYTE_CNT_WD+1:0] FULL_CNT_X = (BYTE_CNT_WD + 2)'(DATA_BYTE_WD);

    logic [DATA_WD-1:0]     w_beat;
    logic [BYTE_CNT_WD+3:0] w_strip_sh;
    logic [BYTE_CNT_WD+3:0] w_res_sh;
    logic [BYTE_CNT_WD+1:0] w_total;

    // Disabled lanes are forced to zero so nothing stale leaks into the
    // header, the residue or the output beat.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_lane_mask
            assign w_beat[gi*8 +: 8] = i_beat_keep[gi] ? i_beat[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // Byte counts scaled to bit shifts; width covers S = DATA_BYTE_WD.
    assign w_strip_sh = {i_strip, 3'b000};
    assign w_res_sh   = {i_res_cnt, 3'b000};

    assign o_header   = w_beat & ~({DATA_WD{1'b1}} >> w_strip_sh);
    assign o_leftover = w_beat << w_strip_sh;
    assign o_merged   = i_residue | (w_beat >> w_res_sh);

    assign o_beat_cnt = keep_count(i_beat_keep);
    assign w_total    = {1'b0, i_res_cnt} + {1'b0, o_beat_cnt};
    assign o_fits     = (w_total <= FULL_CNT_X);
    assign o_out_cnt  = w_total[BYTE_CNT_WD:0];
    assign o_tail_cnt = w_total[BYTE_CNT_WD:0] - FULL_CNT;

endmodule

// File: rtl/axi_stream_remove_header.sv
// -----------------------------------------------------------------------------
// axi_stream_remove_header
// Removes a per-packet number of leading bytes (S = byte_strip_cnt+1) from an
// AXI Stream packet and re-justifies the remaining payload to the MSB lane of
// every output beat. The removed bytes appear on header_out.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   valid_in/ready_in, data_in,
//   keep_in, last_in              : input stream
//   valid_out/ready_out, data_out,
//   keep_out, last_out            : realigned output stream (registered)
//   valid_strip/ready_strip,
//   byte_strip_cnt                : one strip count per packet, taken in IDLE
//   header_out, keep_header,
//   valid_header                  : stripped bytes, one-cycle pulse
//   err_empty                     : pulse when nothing remains after the strip
// -----------------------------------------------------------------------------
module axi_stream_remove_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = AXIS_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    output logic                    valid_header,
    output logic                    err_empty
);

    localparam logic [BYTE_CNT_WD:0] FULL_CNT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
    localparam logic [BYTE_CNT_WD:0] ONE_CNT  = (BYTE_CNT_WD + 1)'(1);

    state_t                  r_state;
    logic [BYTE_CNT_WD:0]    r_strip;
    logic [DATA_WD-1:0]      r_residue;
    logic [BYTE_CNT_WD:0]    r_res_cnt;
    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;
    logic [DATA_WD-1:0]      r_header;
    logic [DATA_BYTE_WD-1:0] r_keep_header;
    logic                    r_valid_header;
    logic                    r_err_empty;

    logic                    w_out_free;
    logic                    w_accept;
    logic [DATA_WD-1:0]      w_header;
    logic [DATA_WD-1:0]      w_merged;
    logic [DATA_WD-1:0]      w_leftover;
    logic [BYTE_CNT_WD:0]    w_beat_cnt;
    logic [BYTE_CNT_WD:0]    w_first_cnt;
    logic [BYTE_CNT_WD:0]    w_out_cnt;
    logic                    w_fits;
    logic [BYTE_CNT_WD:0]    w_tail_cnt;

    axis_byte_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .i_residue   (r_residue),
        .i_res_cnt   (r_res_cnt),
        .i_beat      (data_in),
        .i_beat_keep (keep_in),
        .i_strip     (r_strip),
        .o_header    (w_header),
        .o_merged    (w_merged),
        .o_leftover  (w_leftover),
        .o_beat_cnt  (w_beat_cnt),
        .o_out_cnt   (w_out_cnt),
        .o_fits      (w_fits),
        .o_tail_cnt  (w_tail_cnt)
    );

    // The output register can take a new beat when empty or draining now.
    assign w_out_free = !r_valid_out || ready_out;

    // FIRST may emit an output beat (single-beat packet), so it waits for a
    // free output register just like STREAM; otherwise a stalled last beat
    // of the previous packet could be overwritten.
    assign ready_in    = ((r_state == FIRST) || (r_state == STREAM)) && w_out_free;
    assign ready_strip = (r_state == IDLE);
    assign w_accept    = valid_in && ready_in;

    // Valid bytes left after the strip on a first beat that is also last.
    assign w_first_cnt = w_beat_cnt - r_strip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_strip        <= ONE_CNT;
            r_residue      <= '0;
            r_res_cnt      <= '0;
            r_valid_out    <= 1'b0;
            r_data_out     <= '0;
            r_keep_out     <= '0;
            r_last_out     <= 1'b0;
            r_header       <= '0;
            r_keep_header  <= '0;
            r_valid_header <= 1'b0;
            r_err_empty    <= 1'b0;
        end else begin
            r_valid_header <= 1'b0;
            r_err_empty    <= 1'b0;
            if (w_out_free) begin
                r_valid_out <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (valid_strip) begin
                        r_strip <= {1'b0, byte_strip_cnt} + ONE_CNT;
                        r_state <= FIRST;
                    end
                end

                FIRST: begin
                    if (w_accept) begin
                        r_header       <= w_header;
                        r_keep_header  <= keep_from_count(r_strip);
                        r_valid_header <= 1'b1;
                        r_residue      <= w_leftover;
                        r_res_cnt      <= FULL_CNT - r_strip;
                        if (last_in) begin
                            r_state <= IDLE;
                            if (w_beat_cnt <= r_strip) begin
                                r_err_empty <= 1'b1;
                            end else begin
                                r_valid_out <= 1'b1;
                                r_data_out  <= w_leftover;
                                r_keep_out  <= keep_from_count(w_first_cnt);
                                r_last_out  <= 1'b1;
                            end
                        end else begin
                            r_state <= STREAM;
                        end
                    end
                end

                STREAM: begin
                    if (w_accept) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= w_merged;
                        r_residue   <= w_leftover;
                        if (last_in && w_fits) begin
                            r_keep_out <= keep_from_count(w_out_cnt);
                            r_last_out <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_keep_out <= '1;
                            r_last_out <= 1'b0;
                            // Residue count stays at DATA_BYTE_WD-S mid-packet;
                            // on an overflowing last beat it becomes the tail.
                            if (last_in) begin
                                r_res_cnt <= w_tail_cnt;
                                r_state   <= TAIL;
                            end
                        end
                    end
                end

                TAIL: begin
                    if (w_out_free) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= r_residue;
                        r_keep_out  <= keep_from_count(r_res_cnt);
                        r_last_out  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign valid_out    = r_valid_out;
    assign data_out     = r_data_out;
    assign keep_out     = r_keep_out;
    assign last_out     = r_last_out;
    assign header_out   = r_header;
    assign keep_header  = r_keep_header;
    assign valid_header = r_valid_header;
    assign err_empty    = r_err_empty;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_remove_header
// Directed and random packets. Expected output beats and headers are derived
// from the packet bytes (drop the first S bytes, repack MSB-first) and queued
// when the packet is issued; a monitor pops and compares them on handshakes.
// -----------------------------------------------------------------------------
module tb_axi_stream_remove_header;

    localparam int DW = 32;
    localparam int DB = DW / 8;
    localparam int CW = $clog2(DB);

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_in;
    logic [DB-1:0] keep_in;
    logic          last_in;
    logic          valid_out;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic [DB-1:0] keep_out;
    logic          last_out;
    logic          valid_strip;
    logic          ready_strip;
    logic [CW-1:0] byte_strip_cnt;
    logic [DW-1:0] header_out;
    logic [DB-1:0] keep_header;
    logic          valid_header;
    logic          err_empty;

    axi_stream_remove_header #(
        .DATA_WD (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .valid_strip    (valid_strip),
        .ready_strip    (ready_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .header_out     (header_out),
        .keep_header    (keep_header),
        .valid_header   (valid_header),
        .err_empty      (err_empty)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] hdr;
        logic [DB-1:0] keep;
        logic          err;
    } hdr_t;

    beat_t      exp_q[$];
    hdr_t       hdr_q[$];
    logic [7:0] pkt[$];

    int checks  = 0;
    int errors  = 0;
    bit mon_en  = 0;
    bit rdy_rand = 0;
    int gap_max = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expectations straight from the packet bytes.
    task automatic push_expect(input int s);
        hdr_t  h;
        beat_t e;
        int    n;
        h = '0;
        for (int i = 0; i < s; i++) begin
            h.keep[DB-1-i] = 1'b1;
            if (i < pkt.size()) h.hdr[DW-1-8*i -: 8] = pkt[i];
        end
        h.err = (pkt.size() <= s);
        hdr_q.push_back(h);
        n = pkt.size() - s;
        for (int b = 0; b < n; b += DB) begin
            e = '0;
            for (int j = 0; j < DB; j++) begin
                if (b + j < n) begin
                    e.data[DW-1-8*j -: 8] = pkt[s+b+j];
                    e.keep[DB-1-j]        = 1'b1;
                end
            end
            e.last = (b + DB >= n);
            exp_q.push_back(e);
        end
    endtask

    // Issues strip count then up to max_beats beats of pkt.
    task automatic drive_packet(input int s, input int max_beats);
        bit            hs;
        int            n;
        int            nb;
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        valid_strip    = 1'b1;
        byte_strip_cnt = CW'(s - 1);
        do begin
            @(negedge clk);
            hs = ready_strip;
            @(posedge clk);
            #1;
        end while (!hs);
        valid_strip    = 1'b0;
        byte_strip_cnt = CW'($urandom);
        n  = pkt.size();
        nb = 0;
        for (int b = 0; b < n && nb < max_beats; b += DB) begin
            repeat ($urandom_range(0, gap_max)) begin
                valid_in = 1'b0;
                data_in  = $urandom;
                @(posedge clk);
                #1;
            end
            d = '0;
            k = '0;
            for (int j = 0; j < DB; j++) begin
                if (b + j < n) begin
                    d[DW-1-8*j -: 8] = pkt[b+j];
                    k[DB-1-j]        = 1'b1;
                end else begin
                    d[DW-1-8*j -: 8] = 8'($urandom);
                end
            end
            valid_in = 1'b1;
            data_in  = d;
            keep_in  = k;
            last_in  = (b + DB >= n);
            do begin
                @(negedge clk);
                hs = ready_in;
                @(posedge clk);
                #1;
            end while (!hs);
            valid_in = 1'b0;
            last_in  = 1'b0;
            nb++;
        end
    endtask

    task automatic send(input int s);
        push_expect(s);
        drive_packet(s, 1 << 20);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", 64'(exp_q.size() + hdr_q.size()), 64'd0);
    endtask

    // Output ready generator.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_out = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: sampled on the falling edge, between DUT updates.
    initial begin
        beat_t e;
        hdr_t  h;
        beat_t prev;
        bit    prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(valid_out), 64'd1);
                    chk("stall_hold", 64'({data_out, keep_out, last_out}), 64'(prev));
                end
                if (valid_out && ready_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_beat", 64'(valid_out), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", 64'(data_out), 64'(e.data));
                        chk("keep_out", 64'(keep_out), 64'(e.keep));
                        chk("last_out", 64'(last_out), 64'(e.last));
                        $display("beat data=%h keep=%b last=%b", data_out, keep_out, last_out);
                    end
                end
                prev_stall = valid_out && !ready_out;
                prev       = {data_out, keep_out, last_out};
                if (valid_header) begin
                    if (hdr_q.size() == 0) begin
                        chk("unexpected_header", 64'(valid_header), 64'd0);
                    end else begin
                        h = hdr_q.pop_front();
                        chk("header_out", 64'(header_out), 64'(h.hdr));
                        chk("keep_header", 64'(keep_header), 64'(h.keep));
                        chk("err_empty", 64'(err_empty), 64'(h.err));
                        if (err_empty) chk("ready_strip_after_err", 64'(ready_strip), 64'd1);
                        $display("header=%h keep=%b err=%b", header_out, keep_header, err_empty);
                    end
                end else if (err_empty) begin
                    chk("err_without_header", 64'(err_empty), 64'd0);
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Bound on total run time.
    initial begin
        #(700_000);
        errors++;
        $display("FAIL watchdog: observed no completion, expected end of stimulus");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int s;
        int nb;
        int l;
        rst            = 1'b1;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_last_out", 64'(last_out), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_keep_out", 64'(keep_out), 64'd0);
        chk("rst_header_out", 64'(header_out), 64'd0);
        chk("rst_keep_header", 64'(keep_header), 64'd0);
        chk("rst_valid_header", 64'(valid_header), 64'd0);
        chk("rst_err_empty", 64'(err_empty), 64'd0);
        chk("rst_ready_strip", 64'(ready_strip), 64'd1);
        chk("rst_ready_in", 64'(ready_in), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // S=1, two full beats: output needs a TAIL beat.
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        send(1);
        drain();
        // S=2, last beat keep 1100: single output beat, no TAIL.
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send(2);
        drain();
        // S=4: pass-through of everything after the first beat.
        pkt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        send(4);
        drain();
        // S=4, single full beat: nothing left.
        pkt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send(4);
        drain();
        // S=1, single short beat with bytes remaining.
        pkt = '{8'hC0, 8'hC1, 8'hC2};
        send(1);
        drain();
        // S=3, single beat of exactly 3 bytes: boundary of the empty case.
        pkt = '{8'h55, 8'h66, 8'h77};
        send(3);
        drain();

        // Random packets with random valid gaps and output stalls.
        rdy_rand = 1'b1;
        gap_max  = 2;
        for (int p = 0; p < 1000; p++) begin
            s  = $urandom_range(1, DB);
            nb = $urandom_range(1, 4);
            l  = $urandom_range(1, DB);
            pkt.delete();
            for (int i = 0; i < (nb - 1) * DB + l; i++) pkt.push_back(8'($urandom));
            send(s);
        end
        drain();

        // Reset in the middle of a packet.
        rdy_rand = 1'b0;
        gap_max  = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        pkt = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
        drive_packet(2, 2);
        chk("pre_rst_valid_out", 64'(valid_out), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid_out", 64'(valid_out), 64'd0);
        chk("midrst_ready_strip", 64'(ready_strip), 64'd1);
        chk("midrst_ready_in", 64'(ready_in), 64'd0);
        chk("midrst_keep_out", 64'(keep_out), 64'd0);
        exp_q.delete();
        hdr_q.delete();
        mon_en = 1'b1;
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        send(1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
